float_add_vector_checker: RTL and testbench

Self-checking harness for the single-precision `float_adder`. It holds three internal operand/expected-result vector memories and, on `start`, sequences through up to `DEPTH` vectors. For each vector it drives the embedded adder and compares the sum against the expected word, accumulating pass/fail counts and capturing the first failure. It sits beside `float_adder` as the loadable, multi-vector generalisation of the one-shot adder/comparator test setup.

---
 rtl/float_add_vector_checker.sv | 213 +++++++++++++++++++++
 tb/tb_float_add_vector_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_add_vector_checker.sv
// float_add_vector_checker: loadable multi-vector harness around float_adder.
// Three DEPTHx32 vector memories (A, B, expected) are written while idle; on
// start the FSM walks min(num_vec, DEPTH) vectors, two cycles each (FETCH then
// CHECK), counting matches/mismatches and capturing the first mismatch.
// Optional build macro FADD_CHK_ULP_TOL_EN widens a match to "same sign and
// magnitude within ULP_TOL"; without it the compare is exact 32-bit equality.
//
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
// in DONE; busy is high exactly while vectors are being fetched/checked, and
// memory writes are dropped while busy.

module float_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic        swap, eff_sub, big_s, small_s, sticky, round_up;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  big_e, small_e, diff;
    logic [23:0] big_m, small_m, mant;
    logic [26:0] big_x, small_x, shifted, norm;
    logic [27:0] raw;
    logic [9:0]  exp_w;
    logic [24:0] rounded;

    // Align, add/subtract, normalise and round to nearest-even
    always_comb begin
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        swap    = b[30:0] > a[30:0];
        big_s   = swap ? b[31] : a[31];
        small_s = swap ? a[31] : b[31];
        big_e   = swap ? b[30:23] : a[30:23];
        small_e = swap ? a[30:23] : b[30:23];
        big_m   = {big_e != 8'd0, swap ? b[22:0] : a[22:0]};
        small_m = {small_e != 8'd0, swap ? a[22:0] : b[22:0]};
        // Subnormals share the exponent of the smallest normal (1)
        diff    = (big_e == 8'd0 ? 8'd1 : big_e) - (small_e == 8'd0 ? 8'd1 : small_e);
        big_x   = {big_m, 3'b000};
        small_x = {small_m, 3'b000};
        sticky  = 1'b0;
        if (diff > 8'd26) begin
            shifted = {26'd0, |small_x};
        end else begin
            shifted    = small_x >> diff;
            sticky     = |(small_x & ((27'd1 << diff) - 27'd1));
            shifted[0] = shifted[0] | sticky;
        end
        eff_sub = big_s ^ small_s;
        raw     = eff_sub ? ({1'b0, big_x} - {1'b0, shifted})
                          : ({1'b0, big_x} + {1'b0, shifted});
        exp_w   = {2'b00, (big_e == 8'd0) ? 8'd1 : big_e};
        if (raw[27]) begin
            norm    = raw[27:1];
            norm[0] = raw[1] | raw[0];
            exp_w   = exp_w + 10'd1;
        end else begin
            norm = raw[26:0];
        end
        // Left-normalise, stopping at the subnormal exponent
        for (int i = 0; i < 26; i++) begin
            if (!norm[26] && (exp_w > 10'd1)) begin
                norm  = norm << 1;
                exp_w = exp_w - 10'd1;
            end
        end
        mant     = norm[26:3];
        round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        rounded  = {1'b0, mant} + {24'd0, round_up};
        if (rounded[24]) begin
            mant  = rounded[24:1];
            exp_w = exp_w + 10'd1;
        end else begin
            mant = rounded[23:0];
        end
        if (exp_w >= 10'd255) sum = {big_s, 8'hFF, 23'd0};
        else                  sum = {big_s, mant[23] ? exp_w[7:0] : 8'd0, mant[22:0]};
        if (raw == 28'd0)     sum = {big_s & !eff_sub, 31'd0};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) sum = 32'h7FC0_0000;
        else if (a_inf)       sum = a;
        else if (b_inf)       sum = b;
    end
endmodule

module float_add_vector_checker #(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int ULP_TOL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [1:0]    wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          start,
    input  logic [AW:0]   num_vec,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   pass_cnt,
    output logic [AW:0]   fail_cnt,
    output logic [AW-1:0] first_fail_idx,
    output logic [31:0]   first_fail_sum
);
    typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] idx;
    logic [AW:0]   n;
    logic [31:0]   mem_a [DEPTH];
    logic [31:0]   mem_b [DEPTH];
    logic [31:0]   mem_e [DEPTH];
    logic [31:0]   a_q, b_q, exp_q, sum;
    logic          match, last;

    float_adder u_adder (.a(a_q), .b(b_q), .sum(sum));

`ifdef FADD_CHK_ULP_TOL_EN
    logic [30:0] mag_diff;
    assign mag_diff = (sum[30:0] >= exp_q[30:0]) ? (sum[30:0] - exp_q[30:0])
                                                 : (exp_q[30:0] - sum[30:0]);
    assign match = (sum == exp_q) ||
                   ((sum[31] == exp_q[31]) && (mag_diff <= 31'(ULP_TOL)));
`else
    assign match = (sum == exp_q);
`endif

    assign last = ({1'b0, idx} == (n - (AW+1)'(1)));

    // Vector memories: write port gated by busy, registered read in FETCH
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            case (wr_sel)
                2'd0:    mem_a[wr_addr] <= wr_data;
                2'd1:    mem_b[wr_addr] <= wr_data;
                2'd2:    mem_e[wr_addr] <= wr_data;
                default: ;
            endcase
        end
        if (state == FETCH) begin
            a_q   <= mem_a[idx];
            b_q   <= mem_b[idx];
            exp_q <= mem_e[idx];
        end
    end

    // Run sequencer with registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            n              <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_sum <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_sum <= '0;
                        idx            <= '0;
                        n              <= (num_vec > DEPTH_W) ? DEPTH_W : num_vec;
                        if (num_vec == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                            pass  <= 1'b0;
                        end
                    end
                end
                FETCH: state <= CHECK;
                CHECK: begin
                    if (match) begin
                        pass_cnt <= pass_cnt + (AW+1)'(1);
                    end else begin
                        fail_cnt <= fail_cnt + (AW+1)'(1);
                        if (fail_cnt == '0) begin
                            first_fail_idx <= idx;
                            first_fail_sum <= sum;
                        end
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_cnt == '0) && match;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_add_vector_checker.sv
// Bench for float_add_vector_checker: loads known float sums, runs the
// sequencer and checks end-of-run summaries against a scoreboard queue.
module tb_float_add_vector_checker;
    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int ULP_TOL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_sel = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   num_vec = '0;
    logic          busy, done, pass;
    logic [AW:0]   pass_cnt, fail_cnt;
    logic [AW-1:0] first_fail_idx;
    logic [31:0]   first_fail_sum;

    float_add_vector_checker #(.DEPTH(DEPTH), .AW(AW), .ULP_TOL(ULP_TOL)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .num_vec(num_vec), .busy(busy), .done(done),
        .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_sum(first_fail_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_cycle;
        int          busy_cycles;
        logic        pass;
        logic [AW:0] pass_cnt;
        logic [AW:0] fail_cnt;
        logic [AW-1:0] ffi;
        logic [31:0] ffs;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sh_exp [DEPTH];
    logic [31:0] sh_sum [DEPTH];
    logic [31:0] tab_a [10];
    logic [31:0] tab_b [10];
    logic [31:0] tab_s [10];
    int          checks = 0;
    int          passed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] sel, input int addr, input logic [31:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Load vector k from table row t; corrupt flips the expected LSB
    task automatic load_vec(input int k, input int t, input bit corrupt);
        write_word(2'd0, k, tab_a[t]);
        write_word(2'd1, k, tab_b[t]);
        write_word(2'd2, k, corrupt ? (tab_s[t] ^ 32'h1) : tab_s[t]);
        sh_sum[k] = tab_s[t];
        sh_exp[k] = corrupt ? (tab_s[t] ^ 32'h1) : tab_s[t];
    endtask

    function automatic void predict(input int nv);
        exp_t e;
        int   nn;
        logic ok;
        logic [30:0] da;
        nn = (nv > DEPTH) ? DEPTH : nv;
        e.pass_cnt = '0; e.fail_cnt = '0; e.ffi = '0; e.ffs = '0;
        for (int k = 0; k < nn; k++) begin
            ok = (sh_exp[k] === sh_sum[k]);
`ifdef FADD_CHK_ULP_TOL_EN
            da = (sh_exp[k][30:0] > sh_sum[k][30:0]) ? (sh_exp[k][30:0] - sh_sum[k][30:0])
                                                     : (sh_sum[k][30:0] - sh_exp[k][30:0]);
            ok = ok || ((sh_exp[k][31] == sh_sum[k][31]) && (da <= 31'(ULP_TOL)));
`else
            da = '0;
`endif
            if (ok) e.pass_cnt = e.pass_cnt + 1'b1;
            else begin
                if (e.fail_cnt == 0) begin
                    e.ffi = AW'(k);
                    e.ffs = sh_sum[k];
                end
                e.fail_cnt = e.fail_cnt + 1'b1;
            end
        end
        e.pass        = (e.fail_cnt == 0) && (da == da);
        e.done_cycle  = 2 * nn + 1;
        e.busy_cycles = 2 * nn;
        exp_q.push_back(e);
    endfunction

    // Start a run, wait for done, pop the scoreboard entry and compare
    task automatic run_check(input string tag, input int nv, input bit poke);
        exp_t e;
        int cyc, busy_cyc;
        logic [AW:0] pc_hold;
        predict(nv);
        num_vec = (AW+1)'(nv);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_cyc = 0;
        while (!done && cyc < 200) begin
            if (busy) busy_cyc++;
            if (poke && cyc == 3) begin
                wr_en = 1'b1; wr_sel = 2'd2; wr_addr = '0; wr_data = 32'hDEAD_BEEF;
                start = 1'b1; num_vec = (AW+1)'(1);
            end
            tick();
            cyc++;
            wr_en = 1'b0;
            start = 1'b0;
        end
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || cyc != e.done_cycle) $display("FAIL %s done_cycle: got %0d (done=%b) want %0d", tag, cyc, done, e.done_cycle);
        else passed++;
        checks++;
        if (busy_cyc != e.busy_cycles || busy !== 1'b0) $display("FAIL %s busy_cycles: got %0d (busy=%b) want %0d", tag, busy_cyc, busy, e.busy_cycles);
        else passed++;
        checks++;
        if (pass !== e.pass) $display("FAIL %s pass: got %b want %b", tag, pass, e.pass);
        else passed++;
        checks++;
        if (pass_cnt !== e.pass_cnt) $display("FAIL %s pass_cnt: got %0d want %0d", tag, pass_cnt, e.pass_cnt);
        else passed++;
        checks++;
        if (fail_cnt !== e.fail_cnt) $display("FAIL %s fail_cnt: got %0d want %0d", tag, fail_cnt, e.fail_cnt);
        else passed++;
        checks++;
        if (first_fail_idx !== e.ffi || first_fail_sum !== e.ffs)
            $display("FAIL %s first_fail: got idx %0d sum %h want idx %0d sum %h", tag, first_fail_idx, first_fail_sum, e.ffi, e.ffs);
        else passed++;
        pc_hold = pass_cnt;
        tick();
        tick();
        checks++;
        if (done !== 1'b0 || pass_cnt !== pc_hold || pass !== e.pass)
            $display("FAIL %s hold: got done %b pass_cnt %0d pass %b want done 0 pass_cnt %0d pass %b", tag, done, pass_cnt, pass, pc_hold, e.pass);
        else passed++;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, pass, pass_cnt, fail_cnt, first_fail_idx, first_fail_sum} !== '0)
            $display("FAIL reset_outputs: got busy %b done %b pass %b pc %0d fc %0d idx %0d sum %h want all 0", busy, done, pass, pass_cnt, fail_cnt, first_fail_idx, first_fail_sum);
        else passed++;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_pass();
        load_vec(0, 0, 1'b0);
        run_check("single_pass", 1, 1'b0);
    endtask

    task automatic test_single_fail();
        load_vec(0, 0, 1'b1);
        run_check("single_fail", 1, 1'b0);
    endtask

    task automatic test_adder_table();
        for (int k = 0; k < 10; k++) load_vec(k, k, 1'b0);
        run_check("adder_table", 10, 1'b0);
    endtask

    task automatic test_clamp();
        for (int k = 0; k < DEPTH; k++) load_vec(k, k % 10, (k == 5) || (k == 9));
        run_check("clamp_40", 40, 1'b0);
    endtask

    task automatic test_zero();
        run_check("zero_vec", 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit saw_done;
        for (int k = 0; k < 10; k++) load_vec(k, k, k == 3);
        num_vec = (AW+1)'(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin
            tick();
            cyc++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, pass_cnt, fail_cnt, first_fail_idx, first_fail_sum} !== '0)
            $display("FAIL mid_reset_outputs: got busy %b done %b pc %0d fc %0d want all 0", busy, done, pass_cnt, fail_cnt);
        else passed++;
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (20) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) $display("FAIL mid_reset_no_done: got done pulse want none");
        else passed++;
        run_check("rerun_after_reset", 10, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) load_vec(k, k, k == 6);
        run_check("busy_pokes", 8, 1'b1);
        write_word(2'd3, 0, 32'h0000_0000);
        run_check("memory_intact", 8, 1'b0);
        run_check("back_to_back", 8, 1'b0);
    endtask

    initial begin
        tab_a = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F00_0000,
                  32'h4040_0000, 32'hC000_0000, 32'h42C8_0000, 32'h3F80_0000, 32'h7F80_0000};
        tab_b = '{32'h3F80_0000, 32'h4020_0000, 32'hBF00_0000, 32'hBF80_0000, 32'h3E80_0000,
                  32'h4080_0000, 32'hC040_0000, 32'h3F00_0000, 32'h3380_0000, 32'h3F80_0000};
        tab_s = '{32'h4000_0000, 32'h4080_0000, 32'h3FC0_0000, 32'h0000_0000, 32'h3F40_0000,
                  32'h40E0_0000, 32'hC0A0_0000, 32'h42C9_0000, 32'h3F80_0000, 32'h7F80_0000};
        test_reset();
        test_single_pass();
        test_single_fail();
        test_adder_table();
        test_clamp();
        test_zero();
        test_reset_mid_run();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
